// File: rtl/mtr_pi_req_pkg.sv
// mtr_pi_pkg: shared types and constants for the meter PI requester.
package mtr_pi_pkg;

   // Requester handshake state.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      HONOR = 2'd2,
      DONE  = 2'd3
   } mtr_pi_state_t;

   // Function word handed to microcode: vector flag plus counter select.
   typedef struct packed {
      logic       vector;
      logic [0:1] incr_sel;
   } mtr_func_t;

   // INCR_SEL codes from the meter priority encoder.
   localparam logic [0:1] INCR_TIME  = 2'd0;
   localparam logic [0:1] INCR_PERF  = 2'd1;
   localparam logic [0:1] INCR_EBOX  = 2'd2;
   localparam logic [0:1] INCR_CACHE = 2'd3;

endpackage

// File: rtl/mtr_pi_req_if.sv
// mtr_pi_req_if: meter encoder / PI handshake bundle.
// HONOR_COUNT exists only when MTR_PI_STATS_EN is defined.
interface mtr_pi_req_if;
   logic       MTR_INTERRUPT_REQ;
   logic       VECTOR_REQ;
   logic [0:1] INCR_SEL;
   logic [0:2] MTR_PIA;
   logic       CONO_MTR;
   logic       PI_HONOR;
   logic       PI_DONE;
   logic [1:7] PI_REQ;
   logic       MTR_HONOR;
   logic       FUNC_VALID;
   logic [0:2] FUNC;
`ifdef MTR_PI_STATS_EN
   logic [0:7] HONOR_COUNT;

   // Environment side: meter encoder, CONO and PI system.
   modport master (
      output MTR_INTERRUPT_REQ, VECTOR_REQ, INCR_SEL, MTR_PIA, CONO_MTR,
             PI_HONOR, PI_DONE,
      input  PI_REQ, MTR_HONOR, FUNC_VALID, FUNC, HONOR_COUNT
   );

   // Requester side.
   modport slave (
      input  MTR_INTERRUPT_REQ, VECTOR_REQ, INCR_SEL, MTR_PIA, CONO_MTR,
             PI_HONOR, PI_DONE,
      output PI_REQ, MTR_HONOR, FUNC_VALID, FUNC, HONOR_COUNT
   );
`else
   // Environment side: meter encoder, CONO and PI system.
   modport master (
      output MTR_INTERRUPT_REQ, VECTOR_REQ, INCR_SEL, MTR_PIA, CONO_MTR,
             PI_HONOR, PI_DONE,
      input  PI_REQ, MTR_HONOR, FUNC_VALID, FUNC
   );

   // Requester side.
   modport slave (
      input  MTR_INTERRUPT_REQ, VECTOR_REQ, INCR_SEL, MTR_PIA, CONO_MTR,
             PI_HONOR, PI_DONE,
      output PI_REQ, MTR_HONOR, FUNC_VALID, FUNC
   );
`endif
endinterface

// File: rtl/mtr_pi_req_level_dec.sv
// mtr_pi_level_dec: PI assignment code to one-hot level request; code 0 is no level.
module mtr_pi_level_dec (
   input  logic [0:2] pia,
   input  logic       en,
   output logic [1:7] onehot
);

   // Set the single bit matching the assigned level when enabled.
   always_comb begin
      onehot = '0;
      if (en && (pia != 3'd0)) begin
         onehot[pia] = 1'b1;
      end
   end

endmodule

// File: rtl/mtr_pi.sv
// mtr_pi_req: meter interrupt requester between the MTR priority encoder and PI.
// Optional build macro MTR_PI_STATS_EN adds the HONOR_COUNT service counter.
module mtr_pi_req
   import mtr_pi_pkg::*;
(
   input  logic         clk,
   input  logic         RESET_L,
   mtr_pi_req_if.slave  bus
);

   logic          req_q;
   mtr_func_t     func_q;
   logic [0:2]    pia_q;
   logic [0:2]    pia_nxt;
   logic          lvl_en;
   logic [1:7]    lvl_onehot;
   mtr_pi_state_t state;

   // Level the request should sit on after this edge, including a CONO update.
   always_comb begin
      pia_nxt = bus.CONO_MTR ? bus.MTR_PIA : pia_q;
   end

   assign lvl_en = (state == IDLE) || (state == REQ);

   mtr_pi_level_dec u_level_dec (
      .pia    (pia_nxt),
      .en     (lvl_en),
      .onehot (lvl_onehot)
   );

   // Input sampling stage and PI assignment register.
   always_ff @(posedge clk or negedge RESET_L) begin
      if (!RESET_L) begin
         req_q  <= 1'b0;
         func_q <= '0;
         pia_q  <= '0;
      end else begin
         // The sample taken while DONE still reflects the serviced source, so
         // it is discarded; this also sets the earliest re-request to K+3.
         req_q  <= (state == DONE) ? 1'b0 : bus.MTR_INTERRUPT_REQ;
         func_q <= {bus.VECTOR_REQ, bus.INCR_SEL};
         pia_q  <= pia_nxt;
      end
   end

   // Request/honor handshake FSM with registered outputs.
   always_ff @(posedge clk or negedge RESET_L) begin
      if (!RESET_L) begin
         state          <= IDLE;
         bus.PI_REQ     <= '0;
         bus.MTR_HONOR  <= 1'b0;
         bus.FUNC_VALID <= 1'b0;
         bus.FUNC       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_q && (pia_q != 3'd0)) begin
                  state      <= REQ;
                  bus.FUNC   <= func_q;
                  bus.PI_REQ <= lvl_onehot;
               end
            end
            REQ: begin
               if (bus.PI_HONOR) begin
                  // PI_REQ keeps the level that was granted.
                  state          <= HONOR;
                  bus.MTR_HONOR  <= 1'b1;
                  bus.FUNC_VALID <= 1'b1;
               end else if ((pia_nxt == 3'd0) || !req_q) begin
                  state      <= IDLE;
                  bus.PI_REQ <= '0;
               end else begin
                  bus.PI_REQ <= lvl_onehot;
               end
            end
            HONOR: begin
               if (bus.PI_DONE) begin
                  state          <= DONE;
                  bus.PI_REQ     <= '0;
                  bus.MTR_HONOR  <= 1'b0;
                  bus.FUNC_VALID <= 1'b0;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef MTR_PI_STATS_EN
   // Completed-service counter; CONO clear takes priority over an increment.
   always_ff @(posedge clk or negedge RESET_L) begin
      if (!RESET_L) begin
         bus.HONOR_COUNT <= '0;
      end else if (bus.CONO_MTR) begin
         bus.HONOR_COUNT <= '0;
      end else if ((state == HONOR) && bus.PI_DONE) begin
         bus.HONOR_COUNT <= bus.HONOR_COUNT + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mtr_pi_req.sv
// tb_mtr_pi_req: directed bench with a cycle model of the requester rules.
module tb_mtr_pi_req;
   import mtr_pi_pkg::*;

   logic clk = 1'b0;
   logic RESET_L = 1'b0;
   int   total = 0;
   int   bad = 0;

   mtr_pi_req_if bus ();

   mtr_pi_req dut (
      .clk     (clk),
      .RESET_L (RESET_L),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // ---------------- model ----------------
   // mode: 0 idle, 1 requesting, 2 honored, 3 service-done cycle
   int         m_mode = 0;
   int         m_lvl = 0;
   int         m_pia = 0;
   bit         m_rq = 1'b0;
   logic [0:2] m_fv = '0;
   logic [0:2] m_func = '0;
   int         m_cnt = 0;

   function automatic logic [1:7] onehot(input int lvl);
      logic [1:7] v;
      v = '0;
      if (lvl >= 1 && lvl <= 7) v = 7'b1000000 >> (lvl - 1);
      return v;
   endfunction

   task automatic model_step();
      int new_pia;
      int old_mode;
      new_pia  = bus.CONO_MTR ? int'(bus.MTR_PIA) : m_pia;
      old_mode = m_mode;
      case (m_mode)
         0: if (m_rq && m_pia != 0) begin
               m_mode = 1; m_func = m_fv; m_lvl = new_pia;
            end
         1: if (bus.PI_HONOR) m_mode = 2;
            else if (new_pia == 0 || !m_rq) m_mode = 0;
            else m_lvl = new_pia;
         2: if (bus.PI_DONE) begin
               m_mode = 3; m_cnt = (m_cnt + 1) % 256;
            end
         default: m_mode = 0;
      endcase
      if (bus.CONO_MTR) m_cnt = 0;
      m_rq  = (old_mode == 3) ? 1'b0 : bus.MTR_INTERRUPT_REQ;
      m_fv  = {bus.VECTOR_REQ, bus.INCR_SEL};
      m_pia = new_pia;
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge RESET_L);
         if (!RESET_L) begin
            m_mode = 0; m_lvl = 0; m_pia = 0; m_rq = 1'b0;
            m_fv = '0; m_func = '0; m_cnt = 0;
         end else begin
            model_step();
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Per-cycle comparison against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (RESET_L) begin
            chk("cyc_pi_req", 32'(bus.PI_REQ),
                (m_mode == 1 || m_mode == 2) ? 32'(onehot(m_lvl)) : 32'd0);
            chk("cyc_mtr_honor", 32'(bus.MTR_HONOR), 32'(m_mode == 2));
            chk("cyc_func_valid", 32'(bus.FUNC_VALID), 32'(m_mode == 2));
            chk("cyc_func", 32'(bus.FUNC), 32'(m_func));
`ifdef MTR_PI_STATS_EN
            chk("cyc_honor_count", 32'(bus.HONOR_COUNT), 32'(m_cnt));
`endif
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic lit(input string tag, input logic [1:7] pr, input logic mh,
                      input logic fvd, input logic [0:2] f);
      chk({tag, "_pi_req"}, 32'(bus.PI_REQ), 32'(pr));
      chk({tag, "_mtr_honor"}, 32'(bus.MTR_HONOR), 32'(mh));
      chk({tag, "_func_valid"}, 32'(bus.FUNC_VALID), 32'(fvd));
      chk({tag, "_func"}, 32'(bus.FUNC), 32'(f));
   endtask

   task automatic cono(input logic [0:2] pia);
      bus.CONO_MTR = 1'b1; bus.MTR_PIA = pia;
      cyc(1);
      bus.CONO_MTR = 1'b0;
   endtask

   // One full service from request to completion, bounded wait for PI_REQ.
   task automatic service(input bit cono_at_done);
      int waited;
      bus.MTR_INTERRUPT_REQ = 1'b1;
      waited = 0;
      while (bus.PI_REQ == '0 && waited < 10) begin
         cyc(1); waited++;
      end
      chk("svc_req_seen", 32'(bus.PI_REQ != '0), 32'd1);
      bus.PI_HONOR = 1'b1;
      cyc(1);
      bus.PI_HONOR = 1'b0;
      bus.PI_DONE = 1'b1;
      if (cono_at_done) begin
         bus.CONO_MTR = 1'b1; bus.MTR_PIA = 3'd1;
      end
      cyc(1);
      bus.PI_DONE = 1'b0; bus.CONO_MTR = 1'b0;
      bus.MTR_INTERRUPT_REQ = 1'b0;
      cyc(3);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      bus.MTR_INTERRUPT_REQ = 1'b0; bus.VECTOR_REQ = 1'b0; bus.INCR_SEL = INCR_TIME;
      bus.MTR_PIA = '0; bus.CONO_MTR = 1'b0; bus.PI_HONOR = 1'b0; bus.PI_DONE = 1'b0;

      #3;
      lit("reset", 7'b0000000, 1'b0, 1'b0, 3'b000);
      chk("reset_pia_q", 32'(dut.pia_q), 32'd0);
      cyc(2);
      RESET_L = 1'b1;
      cyc(1);

      // Level 3, ebox select, no vector: two-cycle request latency.
      cono(3'd3);
      bus.MTR_INTERRUPT_REQ = 1'b1; bus.INCR_SEL = INCR_EBOX; bus.VECTOR_REQ = 1'b0;
      cyc(1);
      lit("lat1", 7'b0000000, 1'b0, 1'b0, 3'b000);
      cyc(1);
      lit("req3", 7'b0010000, 1'b0, 1'b0, 3'b010);
      bus.PI_HONOR = 1'b1;
      cyc(1);
      bus.PI_HONOR = 1'b0;
      lit("hon3", 7'b0010000, 1'b1, 1'b1, 3'b010);
      bus.INCR_SEL = INCR_CACHE;
      cyc(3);
      lit("hon3_hold", 7'b0010000, 1'b1, 1'b1, 3'b010);
      bus.PI_DONE = 1'b1;
      cyc(1);
      bus.PI_DONE = 1'b0;
      lit("done3", 7'b0000000, 1'b0, 1'b0, 3'b010);
      cyc(1);
      lit("idle_k1", 7'b0000000, 1'b0, 1'b0, 3'b010);
      cyc(1);
      lit("idle_k2", 7'b0000000, 1'b0, 1'b0, 3'b010);
      cyc(1);
      lit("rereq_k3", 7'b0010000, 1'b0, 1'b0, 3'b011);
      bus.MTR_INTERRUPT_REQ = 1'b0;
      cyc(2);
      lit("src_clear", 7'b0000000, 1'b0, 1'b0, 3'b011);
      bus.PI_HONOR = 1'b1;
      cyc(1);
      bus.PI_HONOR = 1'b0;
      lit("honor_idle_ignored", 7'b0000000, 1'b0, 1'b0, 3'b011);

      // Meter interrupts disabled: request held 20 cycles, nothing happens.
      cono(3'd0);
      bus.MTR_INTERRUPT_REQ = 1'b1;
      cyc(20);
      lit("pia0", 7'b0000000, 1'b0, 1'b0, 3'b011);

      // Level 5, then move to level 2, then withdraw.
      bus.VECTOR_REQ = 1'b1; bus.INCR_SEL = INCR_PERF;
      cono(3'd5);
      cyc(1);
      lit("req5", 7'b0000100, 1'b0, 1'b0, 3'b101);
      bus.PI_DONE = 1'b1;
      cyc(1);
      bus.PI_DONE = 1'b0;
      lit("done_req_ignored", 7'b0000100, 1'b0, 1'b0, 3'b101);
      cono(3'd2);
      lit("move2", 7'b0100000, 1'b0, 1'b0, 3'b101);
      cyc(1);
      cono(3'd0);
      lit("withdraw", 7'b0000000, 1'b0, 1'b0, 3'b101);
      cyc(2);

      // Honor and CONO(0) together: honor wins, level held, pia_q cleared.
      bus.VECTOR_REQ = 1'b0; bus.INCR_SEL = INCR_TIME;
      cono(3'd6);
      cyc(1);
      lit("req6", 7'b0000010, 1'b0, 1'b0, 3'b000);
      bus.PI_HONOR = 1'b1; bus.CONO_MTR = 1'b1; bus.MTR_PIA = 3'd0;
      cyc(1);
      bus.PI_HONOR = 1'b0; bus.CONO_MTR = 1'b0;
      lit("hon_vs_cono", 7'b0000010, 1'b1, 1'b1, 3'b000);
      chk("hon_vs_cono_pia_q", 32'(dut.pia_q), 32'd0);

      // Asynchronous reset in the middle of HONOR.
      #1;
      RESET_L = 1'b0;
      #1;
      lit("async_rst", 7'b0000000, 1'b0, 1'b0, 3'b000);
      cyc(2);
      RESET_L = 1'b1;
      cono(3'd4);
      lit("post_rst_e1", 7'b0000000, 1'b0, 1'b0, 3'b000);
      cyc(1);
      lit("post_rst_e2", 7'b0001000, 1'b0, 1'b0, 3'b000);
      bus.PI_HONOR = 1'b1;
      cyc(1);
      bus.PI_HONOR = 1'b0;
      bus.PI_DONE = 1'b1;
      cyc(1);
      bus.PI_DONE = 1'b0;
      bus.MTR_INTERRUPT_REQ = 1'b0;
      cyc(3);

`ifdef MTR_PI_STATS_EN
      cono(3'd1);
      chk("cnt_clear", 32'(bus.HONOR_COUNT), 32'd0);
      for (int i = 0; i < 255; i++) service(1'b0);
      chk("cnt_255", 32'(bus.HONOR_COUNT), 32'd255);
      service(1'b0);
      chk("cnt_wrap", 32'(bus.HONOR_COUNT), 32'd0);
      service(1'b0);
      chk("cnt_one", 32'(bus.HONOR_COUNT), 32'd1);
      service(1'b1);
      chk("cnt_cono_at_done", 32'(bus.HONOR_COUNT), 32'd0);
`else
      cono(3'd1);
      service(1'b0);
      service(1'b0);
`endif

      cyc(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
